run_host: RTL

Host-side sequencer that drives the processor's `req`/`done` session protocol from the initiator end. It sits between an external loader/consumer and the core plus its data memory, and runs one session at a time:

- preloads data memory through a backdoor write port;
- holds the core in reset, then releases it and pulses `req`;
- waits for `done`, with a cycle timeout;
- freezes the core and streams a window of data memory back out.

---
 rtl/run_host_if.sv | 53 +++++
 rtl/run_host.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/run_host_if.sv
// run_host_if: groups the session-side signals of run_host.
//   start/rd_base/rd_len      session request from the loader
//   ld_*                      load beats (valid/ready handshake)
//   core_*                    core reset, req pulse and done
//   mem_*                     data-memory backdoor port (rdata is combinational)
//   res_*                     readback stream (valid/ready handshake)
//   busy/session_done/timed_out/run_cycles  session status
// Modport slave is the sequencer side; master is the environment side.
interface run_host_if #(
   parameter int AW = 8,
   parameter int DW = 8,
   parameter int CW = 16
);
   logic          start;
   logic [AW-1:0] rd_base;
   logic [AW:0]   rd_len;
   logic          ld_valid;
   logic          ld_ready;
   logic [AW-1:0] ld_addr;
   logic [DW-1:0] ld_data;
   logic          ld_last;
   logic          core_reset;
   logic          core_req;
   logic          core_done;
   logic          mem_wr_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          res_valid;
   logic          res_ready;
   logic [AW-1:0] res_addr;
   logic [DW-1:0] res_data;
   logic          busy;
   logic          session_done;
   logic          timed_out;
   logic [CW-1:0] run_cycles;

   modport slave (
      input  start, rd_base, rd_len, ld_valid, ld_addr, ld_data, ld_last,
             core_done, mem_rdata, res_ready,
      output ld_ready, core_reset, core_req, mem_wr_en, mem_addr, mem_wdata,
             res_valid, res_addr, res_data, busy, session_done, timed_out,
             run_cycles
   );

   modport master (
      output start, rd_base, rd_len, ld_valid, ld_addr, ld_data, ld_last,
             core_done, mem_rdata, res_ready,
      input  ld_ready, core_reset, core_req, mem_wr_en, mem_addr, mem_wdata,
             res_valid, res_addr, res_data, busy, session_done, timed_out,
             run_cycles
   );
endinterface

// File: rtl/run_host.sv
// run_host: host-side sequencer for the core's req/done session protocol.
// One session: preload data memory, hold the core in reset, release it and
// pulse req, wait for done (bounded by TIMEOUT), then freeze the core and
// stream a window of data memory back out.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    run_host_if.slave carrying the load, core, memory, readback and
//          status signals
module run_host #(
   parameter int AW      = 8,
   parameter int DW      = 8,
   parameter int RST_CYC = 2,
   parameter int CW      = 16,
   parameter int TIMEOUT = 4095
) (
   input logic       clk,
   input logic       reset,
   run_host_if.slave bus
);
   localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
   localparam logic [RCW-1:0] RST_LAST  = RCW'(RST_CYC - 1);
   localparam logic [CW-1:0]  TIMEOUT_C = CW'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_RSTC = 3'd2,
      S_RUN  = 3'd3,
      S_READ = 3'd4,
      S_FIN  = 3'd5
   } state_t;

   state_t         state_q, state_d;
   logic [AW-1:0]  base_q, base_d;
   logic [AW:0]    len_q, len_d;
   logic [AW:0]    idx_q, idx_d;
   logic [RCW-1:0] rcnt_q, rcnt_d;
   logic [CW-1:0]  runc_q, runc_d;
   logic           tmo_q, tmo_d;

   logic [CW-1:0]  runc_inc_s;
   logic [AW-1:0]  rd_addr_s;
   logic           ld_ready_s, core_reset_s, core_req_s, mem_wr_en_s;
   logic [AW-1:0]  mem_addr_s, res_addr_s;
   logic [DW-1:0]  mem_wdata_s, res_data_s;
   logic           res_valid_s, session_done_s;

   // State and session registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         len_q   <= '0;
         idx_q   <= '0;
         rcnt_q  <= '0;
         runc_q  <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         rcnt_q  <= rcnt_d;
         runc_q  <= runc_d;
         tmo_q   <= tmo_d;
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_d        = state_q;
      base_d         = base_q;
      len_d          = len_q;
      idx_d          = idx_q;
      rcnt_d         = rcnt_q;
      runc_d         = runc_q;
      tmo_d          = tmo_q;
      runc_inc_s     = runc_q + CW'(1);
      rd_addr_s      = base_q + idx_q[AW-1:0];
      ld_ready_s     = 1'b0;
      core_reset_s   = 1'b1;
      core_req_s     = 1'b0;
      mem_wr_en_s    = 1'b0;
      mem_addr_s     = '0;
      mem_wdata_s    = '0;
      res_valid_s    = 1'b0;
      res_addr_s     = '0;
      res_data_s     = '0;
      session_done_s = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               base_d  = bus.rd_base;
               len_d   = bus.rd_len;
               idx_d   = '0;
               tmo_d   = 1'b0;
               runc_d  = '0;
               state_d = S_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LOAD: begin
            ld_ready_s = 1'b1;
            if (bus.ld_valid) begin
               mem_wr_en_s = 1'b1;
               mem_addr_s  = bus.ld_addr;
               mem_wdata_s = bus.ld_data;
               if (bus.ld_last) begin
                  rcnt_d  = '0;
                  state_d = S_RSTC;
               end else begin
                  state_d = S_LOAD;
               end
            end else begin
               state_d = S_LOAD;
            end
         end
         S_RSTC: begin
            if (rcnt_q == RST_LAST) begin
               state_d = S_RUN;
            end else begin
               rcnt_d = rcnt_q + RCW'(1);
            end
         end
         S_RUN: begin
            core_reset_s = 1'b0;
            // run_cycles was cleared at start and counts every RUN cycle
            // without done, so it is zero only in the first RUN cycle.
            core_req_s   = (runc_q == '0);
            if (bus.core_done) begin
               state_d = S_READ;
            end else begin
               runc_d = runc_inc_s;
               if (runc_inc_s == TIMEOUT_C) begin
                  tmo_d   = 1'b1;
                  state_d = S_READ;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_READ: begin
            if (len_q == '0) begin
               state_d = S_FIN;
            end else begin
               mem_addr_s  = rd_addr_s;
               res_valid_s = 1'b1;
               res_addr_s  = rd_addr_s;
               res_data_s  = bus.mem_rdata;
               if (bus.res_ready) begin
                  if ((idx_q + (AW+1)'(1)) == len_q) begin
                     state_d = S_FIN;
                  end else begin
                     idx_d = idx_q + (AW+1)'(1);
                  end
               end else begin
                  idx_d = idx_q;
               end
            end
         end
         S_FIN: begin
            session_done_s = 1'b1;
            state_d        = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.ld_ready     = ld_ready_s;
   assign bus.core_reset   = core_reset_s;
   assign bus.core_req     = core_req_s;
   assign bus.mem_wr_en    = mem_wr_en_s;
   assign bus.mem_addr     = mem_addr_s;
   assign bus.mem_wdata    = mem_wdata_s;
   assign bus.res_valid    = res_valid_s;
   assign bus.res_addr     = res_addr_s;
   assign bus.res_data     = res_data_s;
   assign bus.session_done = session_done_s;
   assign bus.busy         = (state_q != S_IDLE);
   assign bus.timed_out    = tmo_q;
   assign bus.run_cycles   = runc_q;
endmodule
